// File: rtl/mpmc12_state_machine_fta_if.sv
// Bundle of the arbiter-side and DDR app-side signals of one mpmc12 port
// sequencer. The sequencer uses the master view; whatever models the fifo
// arbiter and the DDR app interface uses the slave view.
interface mpmc12_state_machine_fta_if #(
   parameter int BURST_W = 8
);
   // arbiter / fifo side
   logic               calib_complete;
   logic               rst_busy;
   logic               req_v;
   logic               req_we;
   logic               req_atomic;
   logic [BURST_W-1:0] req_burst;
   logic               select_next;
   // refresh handshake
   logic               ref_req;
   logic               ref_ack;
   logic               app_ref_req;
   logic               app_ref_ack;
   // DDR app command / data side
   logic               app_en;
   logic               app_rdy;
   logic               app_wdf_wren;
   logic               app_wdf_end;
   logic               app_wdf_rdy;
   logic               app_rd_valid;
   logic               rmw_hit;
   // status
   logic [BURST_W-1:0] req_cnt;
   logic [BURST_W-1:0] resp_cnt;
   logic [3:0]         state;
   logic               timeout;

   modport master (
      input  calib_complete, rst_busy, req_v, req_we, req_atomic, req_burst,
             ref_req, app_ref_ack, app_rdy, app_wdf_rdy, app_rd_valid, rmw_hit,
      output select_next, ref_ack, app_ref_req, app_en, app_wdf_wren,
             app_wdf_end, req_cnt, resp_cnt, state, timeout
   );

   modport slave (
      output calib_complete, rst_busy, req_v, req_we, req_atomic, req_burst,
             ref_req, app_ref_ack, app_rdy, app_wdf_rdy, app_rd_valid, rmw_hit,
      input  select_next, ref_ack, app_ref_req, app_en, app_wdf_wren,
             app_wdf_end, req_cnt, resp_cnt, state, timeout
   );
endinterface

// File: rtl/mpmc12_state_machine_fta.sv
// Per-port command sequencer of the mpmc12 memory controller. Takes one
// arbitrated request at a time from the input fifos and turns it into DDR
// app-interface command/write-data strobes, with refresh arbitration and a
// per-state watchdog.
// Optional feature macro: MPMC12_RMW_EN -- when defined, atomic requests run
// a read / ALU / write-back sequence (states ALU, ALU_EXE, WRITE_TRAMP);
// when undefined, atomics complete as plain reads.
module mpmc12_state_machine_fta #(
   parameter int BURST_W       = 8,
   parameter int MAX_BURST     = 7,
   parameter int PRESET_CYCLES = 3,
   parameter int TO_CYCLES     = 1023
) (
   input  logic                                clk,
   input  logic                                rst_n,
   mpmc12_state_machine_fta_if.master          bus
);

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_REFRESH     = 4'd1,
      S_PRESET      = 4'd2,
      S_WRITE       = 4'd3,
      S_READ_REQ    = 4'd4,
      S_READ_WAIT   = 4'd5,
      S_ALU         = 4'd6,
      S_ALU_EXE     = 4'd7,
      S_WRITE_TRAMP = 4'd8
   } state_t;

   // The dwell counter doubles as PRESET / ALU_EXE length counter and watchdog.
   localparam int                 TO_W        = $clog2(TO_CYCLES + 1);
   localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(TO_CYCLES - 1);
   localparam logic [TO_W-1:0]    PRESET_LAST = TO_W'(PRESET_CYCLES - 1);
   localparam logic [BURST_W-1:0] BURST_MAX   = BURST_W'(MAX_BURST);
   localparam logic [BURST_W:0]   ONE_X       = (BURST_W+1)'(1);

   state_t             state_q, state_d;
   logic [TO_W-1:0]    dwell_q;
   logic [BURST_W-1:0] req_cnt_q, resp_cnt_q, burst_q;
   logic               we_q;
   logic               timeout_q;

   logic               sel_c, ref_ack_c, app_en_c, wdf_wren_c, wdf_end_c;
   logic               latch_req, cnt_clr, req_inc, resp_inc, tramp, to_fire;
   logic               can_start;
   logic [BURST_W:0]   beats_needed;
   logic [BURST_W:0]   resp_ext;

`ifdef MPMC12_RMW_EN
   localparam logic [TO_W-1:0] EXE_LAST = TO_W'(3);
   logic atomic_q;
`else
   // Atomic qualifiers have no effect in this build.
   logic unused_rmw;
   assign unused_rmw = bus.req_atomic ^ bus.rmw_hit;
`endif

   assign can_start    = bus.calib_complete && !bus.rst_busy;
   assign beats_needed = {1'b0, burst_q} + ONE_X;
   assign resp_ext     = {1'b0, resp_cnt_q};

   // Next-state and strobe decode for the current state.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      sel_c      = 1'b0;
      ref_ack_c  = 1'b0;
      app_en_c   = 1'b0;
      wdf_wren_c = 1'b0;
      wdf_end_c  = 1'b0;
      latch_req  = 1'b0;
      cnt_clr    = 1'b0;
      req_inc    = 1'b0;
      tramp      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Refresh beats a pending request; the request stays in the fifo.
            if (can_start && bus.ref_req) begin
               state_d = S_REFRESH;
            end else if (can_start && bus.req_v) begin
               state_d   = S_PRESET;
               latch_req = 1'b1;
            end else begin
               sel_c = 1'b1;
            end
         end
         S_REFRESH: begin
            ref_ack_c = 1'b1;
            if (bus.app_ref_ack) state_d = S_IDLE;
         end
         S_PRESET: begin
            cnt_clr = 1'b1;
            if (dwell_q == PRESET_LAST) state_d = we_q ? S_WRITE : S_READ_REQ;
         end
         S_WRITE: begin
            app_en_c   = 1'b1;
            wdf_wren_c = 1'b1;
            wdf_end_c  = (req_cnt_q == burst_q);
            if (bus.app_rdy && bus.app_wdf_rdy) begin
               req_inc = 1'b1;
               if (req_cnt_q == burst_q) state_d = S_IDLE;
            end
         end
         S_READ_REQ: begin
            app_en_c = 1'b1;
            if (bus.app_rdy) begin
               req_inc = 1'b1;
               if (req_cnt_q == burst_q) state_d = S_READ_WAIT;
            end
         end
         S_READ_WAIT: begin
            if (resp_ext == beats_needed) begin
`ifdef MPMC12_RMW_EN
               state_d = atomic_q ? S_ALU : S_IDLE;
`else
               state_d = S_IDLE;
`endif
            end
         end
`ifdef MPMC12_RMW_EN
         S_ALU: begin
            if (bus.rmw_hit) state_d = S_ALU_EXE;
         end
         S_ALU_EXE: begin
            if (dwell_q == EXE_LAST) state_d = S_WRITE_TRAMP;
         end
         S_WRITE_TRAMP: begin
            // Write-back of the modified line is a single beat.
            tramp   = 1'b1;
            state_d = S_WRITE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Read beats count only while a read is outstanding and never past the burst.
      resp_inc = bus.app_rd_valid &&
                 (state_q == S_READ_REQ || state_q == S_READ_WAIT) &&
                 (resp_ext < beats_needed);

      // Watchdog overrides every other transition and counter update.
      to_fire = (state_q != S_IDLE) && bus.calib_complete && (dwell_q == TO_LAST);
      if (to_fire) begin
         state_d   = S_IDLE;
         latch_req = 1'b0;
         cnt_clr   = 1'b0;
         req_inc   = 1'b0;
         resp_inc  = 1'b0;
         tramp     = 1'b0;
      end
   end

   // State, counters and latched request fields.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values of the others.
      if (!rst_n) begin
         state_q    <= S_IDLE;
         dwell_q    <= '0;
         req_cnt_q  <= '0;
         resp_cnt_q <= '0;
         burst_q    <= '0;
         we_q       <= 1'b0;
         timeout_q  <= 1'b0;
`ifdef MPMC12_RMW_EN
         atomic_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timeout_q <= to_fire;

         if (state_d != state_q)   dwell_q <= '0;
         else if (dwell_q != TO_LAST) dwell_q <= dwell_q + 1'b1;

         if (latch_req) begin
            we_q    <= bus.req_we;
            burst_q <= (bus.req_burst > BURST_MAX) ? BURST_MAX : bus.req_burst;
`ifdef MPMC12_RMW_EN
            atomic_q <= bus.req_atomic;
`endif
         end else if (tramp) begin
            burst_q <= '0;
         end

         if (cnt_clr || tramp)                req_cnt_q <= '0;
         else if (req_inc && req_cnt_q != '1) req_cnt_q <= req_cnt_q + 1'b1;

         if (cnt_clr)                           resp_cnt_q <= '0;
         else if (resp_inc && resp_cnt_q != '1) resp_cnt_q <= resp_cnt_q + 1'b1;
      end
   end

   assign bus.select_next  = sel_c;
   assign bus.ref_ack      = ref_ack_c;
   assign bus.app_ref_req  = ref_ack_c;
   assign bus.app_en       = app_en_c;
   assign bus.app_wdf_wren = wdf_wren_c;
   assign bus.app_wdf_end  = wdf_end_c;
   assign bus.req_cnt      = req_cnt_q;
   assign bus.resp_cnt     = resp_cnt_q;
   assign bus.state        = state_q;
   assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_mpmc12_state_machine_fta.sv
// Directed bench for mpmc12_state_machine_fta. Each scenario task drives the
// inputs cycle by cycle and queues the outputs the sequencer must show in that
// cycle, derived from the transaction (burst length, data delay, preset length,
// watchdog length). One compare process checks every queued cycle on the
// falling edge; a few literal expectations pin the generated traces.
module tb_mpmc12_state_machine_fta;

   localparam int BW   = 8;
   localparam int MAXB = 7;
   localparam int PRE  = 3;
   localparam int TO   = 1023;

   localparam logic [3:0] IDLE = 4'd0, REFRESH = 4'd1, PRESET = 4'd2, WRITE = 4'd3,
                          RREQ = 4'd4, RWAIT = 4'd5, ALU = 4'd6, ALU_EXE = 4'd7,
                          TRAMP = 4'd8;

   typedef struct {
      logic [3:0] st;
      logic       en;
      logic       wren;
      logic       wend;
      int         req;
      int         resp;
      logic       rf;
      logic       to;
      logic       sel;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mpmc12_state_machine_fta_if #(.BURST_W(BW)) bus ();

   mpmc12_state_machine_fta #(
      .BURST_W(BW), .MAX_BURST(MAXB), .PRESET_CYCLES(PRE), .TO_CYCLES(TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t cur;
   int   en_seen = 0, ref_seen = 0, to_seen = 0;
   int   m_req = 0, m_resp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // Per-cycle comparison against the queued expectations.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check("state",        32'(bus.state),        32'(cur.st));
         check("app_en",       32'(bus.app_en),       32'(cur.en));
         check("app_wdf_wren", 32'(bus.app_wdf_wren), 32'(cur.wren));
         check("app_wdf_end",  32'(bus.app_wdf_end),  32'(cur.wend));
         check("req_cnt",      32'(bus.req_cnt),      32'(cur.req));
         check("resp_cnt",     32'(bus.resp_cnt),     32'(cur.resp));
         check("ref_ack",      32'(bus.ref_ack),      32'(cur.rf));
         check("app_ref_req",  32'(bus.app_ref_req),  32'(cur.rf));
         check("timeout",      32'(bus.timeout),      32'(cur.to));
         check("select_next",  32'(bus.select_next),  32'(cur.sel));
      end
      if (bus.app_en)  en_seen++;
      if (bus.ref_ack) ref_seen++;
      if (bus.timeout) to_seen++;
   end

   function automatic exp_t mk(input logic [3:0] st, input int req, input int resp);
      exp_t e;
      e.st   = st;
      e.en   = (st == WRITE) || (st == RREQ);
      e.wren = (st == WRITE);
      e.wend = 1'b0;
      e.req  = req;
      e.resp = resp;
      e.rf   = (st == REFRESH);
      e.to   = 1'b0;
      e.sel  = 1'b0;
      return e;
   endfunction

   // Queue the expectation for the current cycle and move to the next one.
   task automatic step(input exp_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic sel);
      exp_t e;
      e     = mk(IDLE, m_req, m_resp);
      e.sel = sel;
      step(e);
   endtask

   // Counters still show the previous transaction during the first preset cycle.
   task automatic preset();
      for (int i = 0; i < PRE; i++) step(mk(PRESET, (i == 0) ? m_req : 0, (i == 0) ? m_resp : 0));
      m_req  = 0;
      m_resp = 0;
   endtask

   task automatic write_beats(input int eff);
      exp_t e;
      for (int k = 0; k <= eff; k++) begin
         e      = mk(WRITE, k, m_resp);
         e.wend = (k == eff);
         step(e);
      end
      m_req = eff + 1;
   endtask

   task automatic dispatch(input int b, input logic we, input logic atomic);
      bus.req_v      = 1'b1;
      bus.req_we     = we;
      bus.req_atomic = atomic;
      bus.req_burst  = BW'(b);
      idle(1'b0);
      bus.req_v      = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_atomic = 1'b0;
      preset();
   endtask

   task automatic write_op(input int b);
      dispatch(b, 1'b1, 1'b0);
      write_beats((b > MAXB) ? MAXB : b);
   endtask

   // Read of b+1 beats; data returns on consecutive cycles starting d0 cycles
   // after the first command (d0 < 0: never).
   task automatic read_op(input int b, input logic atomic, input int d0, output logic timed_out);
      exp_t e;
      int   eff, resp, wait_n;
      logic in_req, v;
      dispatch(b, 1'b0, atomic);
      eff       = (b > MAXB) ? MAXB : b;
      resp      = 0;
      wait_n    = 0;
      timed_out = 1'b0;
      for (int c = 0; c < eff + TO + 8; c++) begin
         in_req           = (c <= eff);
         v                = (d0 >= 0) && (c >= d0) && (c < d0 + eff + 1);
         bus.app_rd_valid = v;
         step(mk(in_req ? RREQ : RWAIT, in_req ? c : eff + 1, resp));
         if (!in_req) begin
            if (resp == eff + 1) break;
            wait_n++;
            if (wait_n == TO) begin
               timed_out = 1'b1;
               break;
            end
         end
         if (v && resp < eff + 1) resp++;
      end
      bus.app_rd_valid = 1'b0;
      m_req  = eff + 1;
      m_resp = resp;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      exp_t e;
      logic tmo;
      bus.calib_complete = 1'b0;
      bus.rst_busy       = 1'b0;
      bus.req_v          = 1'b0;
      bus.req_we         = 1'b0;
      bus.req_atomic     = 1'b0;
      bus.req_burst      = '0;
      bus.ref_req        = 1'b0;
      bus.app_ref_ack    = 1'b0;
      bus.app_rdy        = 1'b1;
      bus.app_wdf_rdy    = 1'b1;
      bus.app_rd_valid   = 1'b0;
      bus.rmw_hit        = 1'b0;

      // Reset state, then hold in IDLE without calibration and during fifo reset.
      repeat (2) @(posedge clk);
      #1;
      idle(1'b1);
      rst_n     = 1'b1;
      bus.req_v = 1'b1;
      idle(1'b1);
      bus.calib_complete = 1'b1;
      bus.rst_busy       = 1'b1;
      idle(1'b1);
      idle(1'b1);
      bus.rst_busy = 1'b0;
      bus.req_v    = 1'b0;
      idle(1'b1);

      // Write burst 3 with ready tied high: four command cycles.
      en_seen = 0;
      write_op(3);
      idle(1'b1);
      check("wr3_beats", 32'(en_seen), 32'd4);

      // Read burst 0, data five cycles after the command.
      read_op(0, 1'b0, 5, tmo);
      idle(1'b1);
      check("rd0_resp_cnt", 32'(bus.resp_cnt), 32'd1);
      check("rd0_no_timeout", 32'(tmo), 32'd0);

      // Refresh and request together: refresh first, then the request.
      ref_seen       = 0;
      bus.ref_req    = 1'b1;
      bus.req_v      = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_burst  = '0;
      idle(1'b0);
      bus.ref_req = 1'b0;
      step(mk(REFRESH, m_req, m_resp));
      step(mk(REFRESH, m_req, m_resp));
      bus.app_ref_ack = 1'b1;
      step(mk(REFRESH, m_req, m_resp));
      bus.app_ref_ack = 1'b0;
      write_op(0);
      idle(1'b1);
      check("ref_cycles", 32'(ref_seen), 32'd3);

      // Read burst 2 with no data: watchdog returns to IDLE with one pulse.
      to_seen = 0;
      read_op(2, 1'b0, -1, tmo);
      check("to_fired", 32'(tmo), 32'd1);
      e     = mk(IDLE, m_req, m_resp);
      e.to  = 1'b1;
      e.sel = 1'b1;
      step(e);
      idle(1'b1);
      idle(1'b1);
      check("to_pulses", 32'(to_seen), 32'd1);
      check("to_req_cnt", 32'(bus.req_cnt), 32'd3);

      // Atomic burst 0.
      read_op(0, 1'b1, 2, tmo);
`ifdef MPMC12_RMW_EN
      for (int i = 0; i < 3; i++) step(mk(ALU, m_req, m_resp));
      bus.rmw_hit = 1'b1;
      step(mk(ALU, m_req, m_resp));
      bus.rmw_hit = 1'b0;
      en_seen = 0;
      for (int i = 0; i < 4; i++) step(mk(ALU_EXE, m_req, m_resp));
      step(mk(TRAMP, m_req, m_resp));
      m_req = 0;
      write_beats(0);
      idle(1'b1);
      check("amo_wb_beats", 32'(en_seen), 32'd1);
`else
      idle(1'b1);
`endif
      check("amo_resp_cnt", 32'(bus.resp_cnt), 32'd1);

      // Oversized request clamps to MAX_BURST+1 beats.
      en_seen = 0;
      write_op(20);
      idle(1'b1);
      check("clamp_beats", 32'(en_seen), 32'd8);

      // Reset in the middle of a burst.
      dispatch(7, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step(mk(WRITE, k, m_resp));
      rst_n = 1'b0;
      step(mk(WRITE, 3, m_resp));
      rst_n  = 1'b1;
      m_req  = 0;
      m_resp = 0;
      idle(1'b1);
      check("rst_state", 32'(bus.state), 32'd0);
      idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
